// File: rtl/fifo_uart_frame_streamer.sv
// Drains the capture FIFO into the UART after a full flag, serialising each
// sample MSB-first as raw bytes or uppercase ASCII hex, with line terminators.
module fifo_uart_frame_streamer #(
  parameter int         SAMPLE_W         = 3,
  parameter logic [7:0] TERM_BYTE        = 8'h0A,
  parameter int         SAMPLES_PER_LINE = 1,
  parameter int         CNT_W            = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_hex_mode,
  input  logic                i_fifo_wrfull,
  input  logic                i_fifo_rdempty,
  input  logic [SAMPLE_W-1:0] i_fifo_q,
  output logic                o_fifo_rdreq,
  input  logic                i_uart_txempty,
  output logic [7:0]          o_uart_tx_data,
  output logic                o_uart_ld_tx_data,
  output logic                o_uart_tx_enable,
  output logic                o_trig_syncrst,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_dump_count,
  output logic [3:0]          o_state_debug
);

  localparam int NB = (SAMPLE_W + 7) / 8;
  localparam int NH = (SAMPLE_W + 3) / 4;
  localparam int LW = $clog2(SAMPLES_PER_LINE + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_READ_REQ = 4'd1,
    S_LATCH    = 4'd2,
    S_WAIT_TX  = 4'd3,
    S_LOAD     = 4'd4,
    S_GAP      = 4'd5,
    S_NEXT     = 4'd6,
    S_DONE     = 4'd7
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_hex;
  logic [31:0]       r_sample;
  logic [3:0]        r_byte_idx;
  logic [LW-1:0]     r_line_cnt;
  logic [CNT_W-1:0]  r_dump_count;
  logic              r_term_sent;
  logic [7:0]        r_tx_data;

  logic [31:0]       w_sample_ext;
  logic [3:0]        w_last_idx;
  logic              w_bytes_left;
  logic              w_line_full;
  logic              w_empty_term;
  logic              w_finish;

  // Byte k of a sample, most significant byte/nibble first.
  function automatic logic [7:0] f_byte(input logic [31:0] s, input logic [3:0] k,
                                        input logic hex);
    logic [31:0] sh;
    logic [3:0]  nib;
    if (hex) begin
      sh  = s >> (4 * (NH - 1 - int'(k)));
      nib = sh[3:0];
      f_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else begin
      sh     = s >> (8 * (NB - 1 - int'(k)));
      f_byte = sh[7:0];
    end
  endfunction

  assign w_sample_ext = 32'(i_fifo_q);
  assign w_last_idx   = r_hex ? 4'(NH - 1) : 4'(NB - 1);
  assign w_bytes_left = !r_term_sent && (r_byte_idx != w_last_idx);
  assign w_line_full  = !r_term_sent && (r_line_cnt == LW'(SAMPLES_PER_LINE));
  assign w_empty_term = i_fifo_rdempty && !r_term_sent;
  assign w_finish     = i_fifo_rdempty && r_term_sent;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state      = r_state;
    o_fifo_rdreq      = 1'b0;
    o_uart_ld_tx_data = 1'b0;
    o_trig_syncrst    = 1'b0;
    case (r_state)
      S_IDLE:     if (i_fifo_wrfull) w_next_state = S_READ_REQ;
      S_READ_REQ: begin
        o_fifo_rdreq = 1'b1;
        w_next_state = S_LATCH;
      end
      S_LATCH:    w_next_state = S_WAIT_TX;
      S_WAIT_TX:  if (i_uart_txempty) w_next_state = S_LOAD;
      S_LOAD: begin
        o_uart_ld_tx_data = 1'b1;
        w_next_state      = S_GAP;
      end
      S_GAP:      w_next_state = S_NEXT;
      S_NEXT: begin
        if (w_bytes_left || w_line_full || w_empty_term) w_next_state = S_WAIT_TX;
        else if (w_finish)                               w_next_state = S_DONE;
        else                                             w_next_state = S_READ_REQ;
      end
      S_DONE: begin
        o_trig_syncrst = 1'b1;
        w_next_state   = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  // The next byte is staged whenever WAIT_TX is entered, so it stays stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hex        <= 1'b0;
      r_sample     <= '0;
      r_byte_idx   <= '0;
      r_line_cnt   <= '0;
      r_dump_count <= '0;
      r_term_sent  <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_fifo_wrfull) begin
            r_hex        <= i_hex_mode;
            r_dump_count <= '0;
            r_line_cnt   <= '0;
            r_term_sent  <= 1'b0;
          end
        end
        S_LATCH: begin
          r_sample    <= w_sample_ext;
          r_byte_idx  <= '0;
          r_term_sent <= 1'b0;
          r_line_cnt  <= r_line_cnt + LW'(1);
          r_tx_data   <= f_byte(w_sample_ext, 4'd0, r_hex);
          if (r_dump_count != {CNT_W{1'b1}}) r_dump_count <= r_dump_count + CNT_W'(1);
        end
        S_NEXT: begin
          if (w_bytes_left) begin
            r_byte_idx <= r_byte_idx + 4'd1;
            r_tx_data  <= f_byte(r_sample, r_byte_idx + 4'd1, r_hex);
          end else if (w_line_full || w_empty_term) begin
            r_line_cnt  <= '0;
            r_term_sent <= 1'b1;
            r_tx_data   <= TERM_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_uart_tx_data   = r_tx_data;
  assign o_uart_tx_enable = 1'b1;
  assign o_busy           = (r_state != S_IDLE);
  assign o_dump_count     = r_dump_count;
  assign o_state_debug    = r_state;

endmodule

// File: tb/tb_fifo_uart_frame_streamer.sv
// Directed bench: three streamer configurations share one clock and reset,
// each fed by a small FIFO model, with UART loads logged into one byte stream.
module tb_fifo_uart_frame_streamer;

  logic clk;
  logic rst;

  logic hexA, wrfullA, rdemptyA, rdreqA, txemptyA, ldA, txEnA, trigA, busyA;
  logic [2:0]  fifoQA;
  logic [7:0]  txDataA;
  logic [15:0] countA;
  logic [3:0]  stateA;

  logic hexB, wrfullB, rdemptyB, rdreqB, txemptyB, ldB, txEnB, trigB, busyB;
  logic [11:0] fifoQB;
  logic [7:0]  txDataB;
  logic [15:0] countB;
  logic [3:0]  stateB;

  logic hexC, wrfullC, rdemptyC, rdreqC, txemptyC, ldC, txEnC, trigC, busyC;
  logic [7:0]  fifoQC;
  logic [7:0]  txDataC;
  logic [15:0] countC;
  logic [3:0]  stateC;

  logic [31:0] memA [0:31];
  logic [31:0] memB [0:31];
  logic [31:0] memC [0:31];
  int cntA, cntB, cntC;
  int ptrA, ptrB, ptrC;

  logic [7:0] txLog [$];
  logic [7:0] expLog [$];
  int cycle, rdCnt, trigCnt, lastLd, trigCycle;
  int checkCount, passCount;

  fifo_uart_frame_streamer #(.SAMPLE_W(3), .TERM_BYTE(8'h0A), .SAMPLES_PER_LINE(1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .i_hex_mode(hexA), .i_fifo_wrfull(wrfullA), .i_fifo_rdempty(rdemptyA),
    .i_fifo_q(fifoQA), .o_fifo_rdreq(rdreqA), .i_uart_txempty(txemptyA), .o_uart_tx_data(txDataA),
    .o_uart_ld_tx_data(ldA), .o_uart_tx_enable(txEnA), .o_trig_syncrst(trigA), .o_busy(busyA),
    .o_dump_count(countA), .o_state_debug(stateA));

  fifo_uart_frame_streamer #(.SAMPLE_W(12), .TERM_BYTE(8'h0A), .SAMPLES_PER_LINE(1), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .i_hex_mode(hexB), .i_fifo_wrfull(wrfullB), .i_fifo_rdempty(rdemptyB),
    .i_fifo_q(fifoQB), .o_fifo_rdreq(rdreqB), .i_uart_txempty(txemptyB), .o_uart_tx_data(txDataB),
    .o_uart_ld_tx_data(ldB), .o_uart_tx_enable(txEnB), .o_trig_syncrst(trigB), .o_busy(busyB),
    .o_dump_count(countB), .o_state_debug(stateB));

  fifo_uart_frame_streamer #(.SAMPLE_W(8), .TERM_BYTE(8'h0A), .SAMPLES_PER_LINE(4), .CNT_W(16)) dutC (
    .clk(clk), .rst(rst), .i_hex_mode(hexC), .i_fifo_wrfull(wrfullC), .i_fifo_rdempty(rdemptyC),
    .i_fifo_q(fifoQC), .o_fifo_rdreq(rdreqC), .i_uart_txempty(txemptyC), .o_uart_tx_data(txDataC),
    .o_uart_ld_tx_data(ldC), .o_uart_tx_enable(txEnC), .o_trig_syncrst(trigC), .o_busy(busyC),
    .o_dump_count(countC), .o_state_debug(stateC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdemptyA = (ptrA >= cntA);
  assign rdemptyB = (ptrB >= cntB);
  assign rdemptyC = (ptrC >= cntC);

  // FIFO read model and UART/trigger observer, sampled mid-cycle.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (rdreqA) begin
      fifoQA <= (ptrA < cntA) ? memA[ptrA][2:0] : 3'd0;
      ptrA   <= ptrA + 1;
    end
    if (rdreqB) begin
      fifoQB <= (ptrB < cntB) ? memB[ptrB][11:0] : 12'd0;
      ptrB   <= ptrB + 1;
    end
    if (rdreqC) begin
      fifoQC <= (ptrC < cntC) ? memC[ptrC][7:0] : 8'd0;
      ptrC   <= ptrC + 1;
    end
    if (rdreqA || rdreqB || rdreqC) rdCnt <= rdCnt + 1;
    if (ldA) begin txLog.push_back(txDataA); lastLd <= cycle; end
    if (ldB) begin txLog.push_back(txDataB); lastLd <= cycle; end
    if (ldC) begin txLog.push_back(txDataC); lastLd <= cycle; end
    if (trigA || trigB || trigC) begin
      trigCnt   <= trigCnt + 1;
      trigCycle <= cycle;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic busyOf(input int which);
    case (which)
      0:       busyOf = busyA;
      1:       busyOf = busyB;
      default: busyOf = busyC;
    endcase
  endfunction

  task automatic startDump(input int which, input logic hex);
    case (which)
      0:       begin hexA = hex; wrfullA = 1'b1; end
      1:       begin hexB = hex; wrfullB = 1'b1; end
      default: begin hexC = hex; wrfullC = 1'b1; end
    endcase
    tick;
    wrfullA = 1'b0;
    wrfullB = 1'b0;
    wrfullC = 1'b0;
  endtask

  task automatic waitIdle(input int which, input string tag);
    for (int i = 0; i < 400; i++) begin
      if (!busyOf(which)) break;
      tick;
    end
    checkOutput({tag, "_idle"}, 32'(busyOf(which)), 32'd0);
  endtask

  task automatic applyStimulus(input int which, input logic hex, input string tag);
    startDump(which, hex);
    waitIdle(which, tag);
  endtask

  task automatic compareLog(input string tag, input int base);
    checkOutput({tag, "_len"}, 32'(txLog.size() - base), 32'(expLog.size()));
    for (int i = 0; i < expLog.size(); i++)
      if (base + i < txLog.size())
        checkOutput($sformatf("%s_b%0d", tag, i), 32'(txLog[base + i]), 32'(expLog[i]));
  endtask

  initial begin
    int base, rd0, tr0;
    logic [7:0] held;
    logic stable, inWait;
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    hexA = 0; wrfullA = 0; txemptyA = 1;
    hexB = 0; wrfullB = 0; txemptyB = 1;
    hexC = 0; wrfullC = 0; txemptyC = 1;
    tick; tick;
    rst = 1'b0;
    tick;

    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_count", 32'(countA), 32'd0);
    checkOutput("rst_state", 32'(stateA), 32'd0);
    checkOutput("rst_txdata", 32'(txDataA), 32'd0);
    checkOutput("rst_rdreq", 32'(rdreqA), 32'd0);
    checkOutput("rst_ld", 32'(ldA), 32'd0);
    checkOutput("rst_trig", 32'(trigA), 32'd0);
    checkOutput("rst_txen", {29'd0, txEnA, txEnB, txEnC}, 32'd7);

    // 3-bit binary, one sample per line
    memA[0] = 32'd5; memA[1] = 32'd2; cntA = 2;
    base = txLog.size(); rd0 = rdCnt; tr0 = trigCnt;
    applyStimulus(0, 1'b0, "bin3");
    expLog = '{8'h05, 8'h0A, 8'h02, 8'h0A};
    compareLog("bin3", base);
    checkOutput("bin3_rdreqs", 32'(rdCnt - rd0), 32'd2);
    checkOutput("bin3_trigs", 32'(trigCnt - tr0), 32'd1);
    checkOutput("bin3_trig_after_ld", 32'(trigCycle > lastLd), 32'd1);
    checkOutput("bin3_count", 32'(countA), 32'd2);

    // 12-bit sample as hex, then as binary
    memB[0] = 32'hA3F; cntB = 1;
    base = txLog.size();
    applyStimulus(1, 1'b1, "hex12");
    expLog = '{8'h41, 8'h33, 8'h46, 8'h0A};
    compareLog("hex12", base);
    checkOutput("hex12_count", 32'(countB), 32'd1);

    memB[1] = 32'hA3F; cntB = 2;
    base = txLog.size();
    applyStimulus(1, 1'b0, "bin12");
    expLog = '{8'h0A, 8'h3F, 8'h0A};
    compareLog("bin12", base);

    // four samples per line, six samples
    for (int i = 0; i < 6; i++) memC[i] = 32'(8'h11 * (i + 1));
    cntC = 6;
    base = txLog.size(); rd0 = rdCnt; tr0 = trigCnt;
    applyStimulus(2, 1'b0, "spl4");
    expLog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0A, 8'h55, 8'h66, 8'h0A};
    compareLog("spl4", base);
    checkOutput("spl4_count", 32'(countC), 32'd6);
    checkOutput("spl4_rdreqs", 32'(rdCnt - rd0), 32'd6);
    checkOutput("spl4_trigs", 32'(trigCnt - tr0), 32'd1);

    // UART stall in WAIT_TX
    memC[6] = 32'h5A; cntC = 7;
    txemptyC = 1'b0;
    base = txLog.size();
    startDump(2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (stateC == 4'd3) break;
      tick;
    end
    checkOutput("stall_enter", 32'(stateC), 32'd3);
    held = txDataC;
    checkOutput("stall_data", 32'(held), 32'h5A);
    stable = 1'b1;
    inWait = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (txDataC !== held) stable = 1'b0;
      if (stateC !== 4'd3 || ldC !== 1'b0) inWait = 1'b0;
    end
    checkOutput("stall_stable", 32'(stable), 32'd1);
    checkOutput("stall_held", 32'(inWait), 32'd1);
    checkOutput("stall_noload", 32'(txLog.size() - base), 32'd0);
    txemptyC = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (txLog.size() > base) break;
      tick;
    end
    txemptyC = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    checkOutput("stall_one_load", 32'(txLog.size() - base), 32'd1);
    checkOutput("stall_rewait", 32'(stateC), 32'd3);
    checkOutput("stall_term_staged", 32'(txDataC), 32'h0A);
    txemptyC = 1'b1;
    waitIdle(2, "stall");
    expLog = '{8'h5A, 8'h0A};
    compareLog("stall", base);

    // reset in the middle of the third byte
    memB[2] = 32'hA3F; cntB = 3;
    base = txLog.size(); tr0 = trigCnt;
    startDump(1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (txLog.size() - base == 2 && stateB == 4'd3) break;
      tick;
    end
    checkOutput("abort_reached", 32'(stateB), 32'd3);
    rst = 1'b1;
    tick;
    checkOutput("abort_busy", 32'(busyB), 32'd0);
    checkOutput("abort_state", 32'(stateB), 32'd0);
    checkOutput("abort_strobes", {29'd0, rdreqB, ldB, trigB}, 32'd0);
    checkOutput("abort_count", 32'(countB), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    checkOutput("abort_no_trig", 32'(trigCnt - tr0), 32'd0);
    checkOutput("abort_bytes", 32'(txLog.size() - base), 32'd2);

    memB[3] = 32'h123; cntB = 4;
    base = txLog.size();
    startDump(1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (stateB == 4'd2) break;
      tick;
    end
    tick;
    checkOutput("restart_count", 32'(countB), 32'd1);
    waitIdle(1, "restart");
    expLog = '{8'h01, 8'h23, 8'h0A};
    compareLog("restart", base);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
